// File: rtl/fetch_pkg.sv
// Fetch-stage shared definitions: FSM state codes and the HALT opcode field.
// No logic, so no latency or backpressure.
package fetch_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_REQ    = 3'd1;
   localparam logic [2:0] ST_VALID  = 3'd2;
   localparam logic [2:0] ST_HALTED = 3'd3;
   localparam logic [2:0] ST_FAULT  = 3'd4;

   localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;

   function automatic logic is_halt(input logic [31:0] word, input logic [5:0] opc);
      return word[OPC_HI:OPC_LO] == opc;
   endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts REQ wait cycles and flags the last permitted one.
// Latency: tc is a decode of the registered count; no backpressure.
module fetch_timeout_counter
   import fetch_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC -> imem request/ready -> decode valid/stall; drives the PC halt.
// Latency: instr_valid one cycle after imem_ready; stall holds the word, halt freezes the PC.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF,
   parameter int         TIMEOUT     = 16,
   parameter int         CNT_W       = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   output logic        halt,
   output logic        halted,
   output logic        fault
);

   logic [2:0] state;
   logic       in_req;
   logic       to_tc;

   assign in_req    = (state == ST_REQ);
   assign imem_addr = pc_in;
   assign imem_req  = in_req;
   // Only a consumed VALID lets the PC move; everything else freezes it.
   assign halt      = ~((state == ST_VALID) & ~stall & ~flush);

   fetch_timeout_counter #(
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk  (clk),
      .reset(reset),
      .clr  (~in_req | imem_ready),
      .en   (in_req & ~imem_ready),
      .tc   (to_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ: begin
               if (imem_ready) begin
                  // A response landing alongside a flush belongs to a stale PC.
                  if (!flush) begin
                     instr       <= imem_rdata;
                     instr_pc    <= pc_in;
                     instr_valid <= 1'b1;
                     state       <= ST_VALID;
                  end
               end else if (to_tc) begin
                  fault <= 1'b1;
                  state <= ST_FAULT;
               end
            end
            ST_VALID: begin
               if (flush) begin
                  instr_valid <= 1'b0;
                  state       <= ST_REQ;
               end else if (!stall) begin
                  instr_valid <= 1'b0;
                  if (is_halt(instr, HALT_OPCODE)) begin
                     halted <= 1'b1;
                     state  <= ST_HALTED;
                  end else begin
                     state <= ST_REQ;
                  end
               end
            end
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC model and a one-wait-cycle memory.
// Latency: memory answers on the second REQ cycle; stall/flush driven per test.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        stall;
   logic        flush;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        halt;
   logic        halted;
   logic        fault;

   logic [31:0] mem [16];
   logic        ready_r;
   logic        mem_en;
   logic        force_ready;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.TIMEOUT(16), .CNT_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_in      (pc_in),
      .stall      (stall),
      .flush      (flush),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .halt       (halt),
      .halted     (halted),
      .fault      (fault)
   );

   // Upstream PC: advances by 4 on every edge where halt is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_in <= '0;
      else if (!halt) pc_in <= pc_in + 32'd4;
   end

   // Memory answers on the cycle after it first sees a request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ready_r <= 1'b0;
      else ready_r <= imem_req & ~ready_r;
   end

   assign imem_ready = (mem_en & ready_r) | force_ready;
   assign imem_rdata = mem[imem_addr[5:2]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_valid(input string tag, input int maxc);
      logic seen = 1'b0;
      for (int i = 0; i < maxc && !seen; i++) begin
         @(negedge clk);
         seen = instr_valid;
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
      mem[0] = 32'h0000_0001;
      mem[1] = 32'h0000_0002;
      mem[2] = 32'h0000_0003;
      mem[3] = 32'h1234_5678;
      mem[4] = 32'hA5A5_0004;
      reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_en = 1'b1; force_ready = 1'b0;

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_valid", instr_valid, 32'd0);
      check("rst_req", imem_req, 32'd0);
      check("rst_halted", halted, 32'd0);
      check("rst_fault", fault, 32'd0);
      check("rst_halt", halt, 32'd1);

      // first fetch: valid on the third edge after release
      reset = 1'b0;
      @(negedge clk);
      check("c1_req", imem_req, 32'd1);
      check("c1_halt", halt, 32'd1);
      check("c1_addr", imem_addr, 32'd0);
      @(negedge clk);
      check("c2_valid", instr_valid, 32'd0);
      @(negedge clk);
      check("c3_valid", instr_valid, 32'd1);
      check("c3_instr", instr, 32'h0000_0001);
      check("c3_pc", instr_pc, 32'd0);
      check("c3_halt", halt, 32'd0);
      check("c3_req", imem_req, 32'd0);

      wait_valid("f2", 8);
      check("f2_pc", instr_pc, 32'd4);
      check("f2_pcin", pc_in, 32'd4);
      check("f2_instr", instr, 32'h0000_0002);
      wait_valid("f3", 8);
      check("f3_pc", instr_pc, 32'd8);
      check("f3_instr", instr, 32'h0000_0003);

      // stall holds the word and the PC
      @(negedge clk);
      stall = 1'b1;
      wait_valid("st", 8);
      for (int i = 0; i < 3; i++) begin
         check("st_instr", instr, 32'h1234_5678);
         check("st_ipc", instr_pc, 32'd12);
         check("st_halt", halt, 32'd1);
         check("st_pcin", pc_in, 32'd12);
         @(negedge clk);
      end
      check("st_held_valid", instr_valid, 32'd1);
      stall = 1'b0;
      #1;
      check("st_release_halt", halt, 32'd0);
      @(negedge clk);
      check("st_pc_once", pc_in, 32'd16);
      check("st_consumed", instr_valid, 32'd0);
      check("st_req", imem_req, 32'd1);

      // flush while stalled, then flush coinciding with ready
      wait_valid("fl", 8);
      stall = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      check("fl_valid", instr_valid, 32'd0);
      check("fl_req", imem_req, 32'd1);
      check("fl_pcin", pc_in, 32'd16);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("fl_discard", instr_valid, 32'd0);
      end
      flush = 1'b0;
      stall = 1'b0;
      wait_valid("fl_after", 8);
      check("fl_after_pc", instr_pc, 32'd16);
      check("fl_after_instr", instr, 32'hA5A5_0004);

      // async reset in the middle of a stuck request
      @(negedge clk);
      mem_en = 1'b0;
      repeat (5) @(negedge clk);
      check("mr_req", imem_req, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("mr_valid", instr_valid, 32'd0);
      check("mr_req0", imem_req, 32'd0);
      check("mr_fault", fault, 32'd0);
      check("mr_halted", halted, 32'd0);
      check("mr_instr", instr, 32'd0);
      check("mr_halt", halt, 32'd1);
      mem[1] = 32'hFC00_0000;
      @(negedge clk);
      reset = 1'b0;
      mem_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("mr_c2_valid", instr_valid, 32'd0);
      @(negedge clk);
      check("mr_c3_valid", instr_valid, 32'd1);
      check("mr_c3_pc", instr_pc, 32'd0);

      // HALT word is terminal
      wait_valid("hl", 8);
      check("hl_instr", instr, 32'hFC00_0000);
      @(negedge clk);
      check("hl_halted", halted, 32'd1);
      check("hl_valid", instr_valid, 32'd0);
      check("hl_pcin", pc_in, 32'd8);
      for (int i = 0; i < 20; i++) begin
         stall = i[0];
         flush = i[1];
         #1;
         check("hl_halt", halt, 32'd1);
         @(negedge clk);
         check("hl_req", imem_req, 32'd0);
         check("hl_sticky", halted, 32'd1);
         check("hl_pc_frozen", pc_in, 32'd8);
      end

      // fetch timeout
      stall = 1'b0;
      flush = 1'b0;
      reset = 1'b1;
      mem_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (16) @(negedge clk);
      check("to_before", fault, 32'd0);
      check("to_before_req", imem_req, 32'd1);
      @(negedge clk);
      check("to_fault", fault, 32'd1);
      check("to_req", imem_req, 32'd0);
      check("to_halt", halt, 32'd1);
      force_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("to_sticky", fault, 32'd1);
         check("to_ignore_ready", instr_valid, 32'd0);
      end
      force_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
